// File: rtl/param_bus_datapath_pkg.sv
// param_bus_datapath_pkg
//   Shared definitions for the single-bus datapath slice.
//   - SRC_* : bus source codes, expressed as offsets above the last
//             general register (code NREG+SRC_x selects source x)
//   - CON_* : condition codes held in IR[20:19] for the CON flip-flop
//   - mem_state_e : memory handshake FSM states
//   - src_w() : width of the encoded bus source select for a given NREG
package param_bus_datapath_pkg;

  localparam int SRC_HI     = 0;
  localparam int SRC_LO     = 1;
  localparam int SRC_ZHI    = 2;
  localparam int SRC_ZLO    = 3;
  localparam int SRC_PC     = 4;
  localparam int SRC_MDR    = 5;
  localparam int SRC_INPORT = 6;
  localparam int SRC_CSEXT  = 7;
  localparam int SRC_EXT    = 8;
  localparam int SRC_COUNT  = 9;

  localparam logic [1:0] CON_EQZ = 2'b00;
  localparam logic [1:0] CON_NEZ = 2'b01;
  localparam logic [1:0] CON_POS = 2'b10;
  localparam logic [1:0] CON_NEG = 2'b11;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WR   = 2'd2
  } mem_state_e;

  function automatic int src_w(input int nreg);
    return $clog2(nreg + SRC_COUNT);
  endfunction

endpackage

// File: rtl/param_bus_datapath_mem_if_fsm.sv
// mem_if_fsm
//   Memory request/acknowledge handshake with wait-state counting and
//   timeout. A one-cycle mem_rd or mem_wr pulse in IDLE starts a transfer;
//   the request stays up until mem_ack or until MAX_WAIT cycles pass
//   without one.
//   Ports:
//     clk, clr        : clock, asynchronous active-low reset
//     mem_rd, mem_wr  : start pulses from the control unit
//     mem_ack         : acknowledge from memory
//     mem_req, mem_we : registered request and write strobe
//     mem_busy        : FSM not IDLE
//     mem_done        : one-cycle completion pulse
//     mem_err         : sticky error (timeout or conflicting start)
//     mem_idle        : FSM in IDLE (MAR may load)
//     rd_active       : FSM in RD (MDR owned by the read)
module mem_if_fsm
  import param_bus_datapath_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic mem_rd,
  input  logic mem_wr,
  input  logic mem_ack,
  output logic mem_req,
  output logic mem_we,
  output logic mem_busy,
  output logic mem_done,
  output logic mem_err,
  output logic mem_idle,
  output logic rd_active
);

  // Counter only has to reach MAX_WAIT-1: the last waiting cycle aborts.
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Next-state logic. Request/strobe flops are loaded from the next state
  // so mem_req rises in the first RD/WR cycle and drops on the exit edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      MEM_IDLE: begin
        cnt_d = '0;
        if (mem_rd && mem_wr) begin
          err_d = 1'b1;
        end else if (mem_rd) begin
          state_d = MEM_RD;
        end else if (mem_wr) begin
          state_d = MEM_WR;
        end
      end
      MEM_RD, MEM_WR: begin
        if (mem_ack) begin
          state_d = MEM_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = MEM_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
    req_d = (state_d != MEM_IDLE);
    we_d  = (state_d == MEM_WR);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_done  = done_q;
  assign mem_err   = err_q;
  assign mem_busy  = (state_q != MEM_IDLE);
  assign mem_idle  = (state_q == MEM_IDLE);
  assign rd_active = (state_q == MEM_RD);

endmodule

// File: rtl/param_bus_datapath.sv
// param_bus_datapath
//   Parametrised single-bus datapath: general registers, HI/LO, PC, IR, Y,
//   double-width Z, MAR/MDR, CON flip-flop and in/out ports, with memory
//   traffic through a req/ack handshake (mem_if_fsm).
//   Ports:
//     clk, clr              : clock, asynchronous active-low reset
//     bus_src, ba_mode      : bus source select, R0-reads-zero mode
//     reg_in .. out_in      : destination load enables
//     ext_bus               : external/debug bus source
//     alu_a, alu_b, alu_res : external ALU operands (Y, bus) and result
//     mem_*                 : memory handshake and status
//     in_data, in_strobe    : input port capture
//     out_port, ir_out, con_out : register outputs
module param_bus_datapath
  import param_bus_datapath_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NREG     = 16,
  parameter  int ADDR_W   = 9,
  parameter  int MAX_WAIT = 15,
  localparam int SRC_W    = src_w(NREG)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [SRC_W-1:0]    bus_src,
  input  logic [NREG-1:0]     reg_in,
  input  logic                hi_in,
  input  logic                lo_in,
  input  logic                pc_in,
  input  logic                ir_in,
  input  logic                y_in,
  input  logic                z_in,
  input  logic                mar_in,
  input  logic                mdr_in,
  input  logic                con_in,
  input  logic                out_in,
  input  logic                ba_mode,
  input  logic [DATA_W-1:0]   ext_bus,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [2*DATA_W-1:0] alu_res,
  input  logic                mem_rd,
  input  logic                mem_wr,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                mem_busy,
  output logic                mem_done,
  output logic                mem_err,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_strobe,
  output logic [DATA_W-1:0]   out_port,
  output logic [DATA_W-1:0]   ir_out,
  output logic                con_out
);

  localparam logic [SRC_W-1:0] CODE_HI     = SRC_W'(NREG + SRC_HI);
  localparam logic [SRC_W-1:0] CODE_LO     = SRC_W'(NREG + SRC_LO);
  localparam logic [SRC_W-1:0] CODE_ZHI    = SRC_W'(NREG + SRC_ZHI);
  localparam logic [SRC_W-1:0] CODE_ZLO    = SRC_W'(NREG + SRC_ZLO);
  localparam logic [SRC_W-1:0] CODE_PC     = SRC_W'(NREG + SRC_PC);
  localparam logic [SRC_W-1:0] CODE_MDR    = SRC_W'(NREG + SRC_MDR);
  localparam logic [SRC_W-1:0] CODE_INPORT = SRC_W'(NREG + SRC_INPORT);
  localparam logic [SRC_W-1:0] CODE_CSEXT  = SRC_W'(NREG + SRC_CSEXT);
  localparam logic [SRC_W-1:0] CODE_EXT    = SRC_W'(NREG + SRC_EXT);

  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, ir_q, ir_d;
  logic [DATA_W-1:0]   y_q, y_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [DATA_W-1:0]   inport_q, inport_d, out_q, out_d;
  logic [2*DATA_W-1:0] z_q, z_d;
  logic                con_q, con_d;

  logic [DATA_W-1:0]   bus;
  logic [DATA_W-1:0]   csext;
  logic                con_cond;
  logic                mem_idle;
  logic                rd_active;
  logic                rd_capture;
  logic                mar_unused;

  assign csext = {{(DATA_W-19){ir_q[18]}}, ir_q[18:0]};

  // Bus source mux. Codes above EXT select nothing and read as zero;
  // ba_mode forces R0 to zero for base-address calculations.
  always_comb begin
    bus = '0;
    for (int i = 0; i < NREG; i++) begin
      if (bus_src == SRC_W'(i)) bus = regs_q[i];
    end
    if (ba_mode && (bus_src == '0)) bus = '0;
    case (bus_src)
      CODE_HI:     bus = hi_q;
      CODE_LO:     bus = lo_q;
      CODE_ZHI:    bus = z_q[2*DATA_W-1:DATA_W];
      CODE_ZLO:    bus = z_q[DATA_W-1:0];
      CODE_PC:     bus = pc_q;
      CODE_MDR:    bus = mdr_q;
      CODE_INPORT: bus = inport_q;
      CODE_CSEXT:  bus = csext;
      CODE_EXT:    bus = ext_bus;
      default:     ;
    endcase
  end

  // Branch condition evaluated on the bus, selected by IR[20:19].
  always_comb begin
    con_cond = 1'b0;
    case (ir_q[20:19])
      CON_EQZ: con_cond = (bus == '0);
      CON_NEZ: con_cond = (bus != '0);
      CON_POS: con_cond = ~bus[DATA_W-1];
      CON_NEG: con_cond = bus[DATA_W-1];
      default: con_cond = 1'b0;
    endcase
  end

  // Register next-state. MAR is frozen while a transfer is in flight so the
  // address stays stable; a read completion owns MDR over mdr_in.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = reg_in[i] ? bus : regs_q[i];
    end
    hi_d     = hi_in ? bus : hi_q;
    lo_d     = lo_in ? bus : lo_q;
    pc_d     = pc_in ? bus : pc_q;
    ir_d     = ir_in ? bus : ir_q;
    y_d      = y_in  ? bus : y_q;
    z_d      = z_in  ? alu_res : z_q;
    out_d    = out_in ? bus : out_q;
    inport_d = in_strobe ? in_data : inport_q;
    con_d    = con_in ? con_cond : con_q;
    mar_d    = (mar_in && mem_idle) ? bus : mar_q;
    mdr_d    = mdr_q;
    if (rd_capture) begin
      mdr_d = mem_rdata;
    end else if (mdr_in && !rd_active) begin
      mdr_d = bus;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      pc_q     <= '0;
      ir_q     <= '0;
      y_q      <= '0;
      z_q      <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      inport_q <= '0;
      out_q    <= '0;
      con_q    <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      y_q      <= y_d;
      z_q      <= z_d;
      mar_q    <= mar_d;
      mdr_q    <= mdr_d;
      inport_q <= inport_d;
      out_q    <= out_d;
      con_q    <= con_d;
    end
  end

  mem_if_fsm #(
    .MAX_WAIT (MAX_WAIT)
  ) u_mem_if_fsm (
    .clk       (clk),
    .clr       (clr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_busy  (mem_busy),
    .mem_done  (mem_done),
    .mem_err   (mem_err),
    .mem_idle  (mem_idle),
    .rd_active (rd_active)
  );

  assign rd_capture = rd_active && mem_ack;

  // Only the low ADDR_W bits of MAR reach memory.
  assign mar_unused = ^mar_q[DATA_W-1:ADDR_W];

  assign alu_a     = y_q;
  assign alu_b     = bus;
  assign mem_addr  = mar_q[ADDR_W-1:0];
  assign mem_wdata = mdr_q;
  assign out_port  = out_q;
  assign ir_out    = ir_q;
  assign con_out   = con_q;

endmodule

// File: tb/tb_param_bus_datapath.sv
// tb_param_bus_datapath
//   Scoreboard bench: each stimulus step pushes the value it should produce,
//   and the value is popped and compared once the DUT has produced it.
module tb_param_bus_datapath;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int SW = 5;

  localparam logic [SW-1:0] S_HI     = 5'd16;
  localparam logic [SW-1:0] S_LO     = 5'd17;
  localparam logic [SW-1:0] S_ZHI    = 5'd18;
  localparam logic [SW-1:0] S_ZLO    = 5'd19;
  localparam logic [SW-1:0] S_PC     = 5'd20;
  localparam logic [SW-1:0] S_INPORT = 5'd22;
  localparam logic [SW-1:0] S_CSEXT  = 5'd23;
  localparam logic [SW-1:0] S_EXT    = 5'd24;

  logic            clk;
  logic            clr;
  logic [SW-1:0]   busSrc;
  logic [NR-1:0]   regIn;
  logic            hiIn, loIn, pcIn, irIn, yIn, zIn, marIn, mdrIn, conIn, outIn;
  logic            baMode;
  logic [DW-1:0]   extBus;
  logic [DW-1:0]   aluA, aluB;
  logic [2*DW-1:0] aluRes;
  logic            memRd, memWr, memReq, memWe, memAck, memBusy, memDone, memErr;
  logic [8:0]      memAddr;
  logic [DW-1:0]   memWdata, memRdata;
  logic [DW-1:0]   inData;
  logic            inStrobe;
  logic [DW-1:0]   outPort, irOut;
  logic            conOut;

  param_bus_datapath #(
    .DATA_W(DW), .NREG(NR), .ADDR_W(9), .MAX_WAIT(15)
  ) dut (
    .clk(clk), .clr(clr), .bus_src(busSrc), .reg_in(regIn),
    .hi_in(hiIn), .lo_in(loIn), .pc_in(pcIn), .ir_in(irIn), .y_in(yIn),
    .z_in(zIn), .mar_in(marIn), .mdr_in(mdrIn), .con_in(conIn), .out_in(outIn),
    .ba_mode(baMode), .ext_bus(extBus), .alu_a(aluA), .alu_b(aluB),
    .alu_res(aluRes), .mem_rd(memRd), .mem_wr(memWr), .mem_req(memReq),
    .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .mem_ack(memAck), .mem_busy(memBusy),
    .mem_done(memDone), .mem_err(memErr), .in_data(inData),
    .in_strobe(inStrobe), .out_port(outPort), .ir_out(irOut), .con_out(conOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecCount = 0;
  int missCount = 0;
  int doneSeen = 0;

  // Completion pulses are tallied on the falling edge, away from updates.
  always @(negedge clk) begin
    if (memDone === 1'b1) doneSeen++;
  end

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t expQ[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    expQ.push_back(e);
  endtask

  task automatic popCheck(input logic [63:0] obs);
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput("sb_underflow", 64'd0, 64'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearEnables();
    regIn = '0; hiIn = 0; loIn = 0; pcIn = 0; irIn = 0; yIn = 0; zIn = 0;
    marIn = 0; mdrIn = 0; conIn = 0; outIn = 0; inStrobe = 0;
  endtask

  // Drive the bus for one clock with whatever enables the caller raised.
  task automatic applyStimulus(input logic [SW-1:0] src, input logic [DW-1:0] ext);
    busSrc = src;
    extBus = ext;
    tick();
    clearEnables();
  endtask

  task automatic readBus(input logic [SW-1:0] src, output logic [DW-1:0] val);
    busSrc = src;
    #1;
    val = aluB;
  endtask

  logic [DW-1:0] v;
  int            reqCycles;
  int            doneBase;

  initial begin
    clr = 1'b1;
    busSrc = '0; extBus = '0; baMode = 0; aluRes = '0;
    memRd = 0; memWr = 0; memAck = 0; memRdata = '0; inData = '0;
    clearEnables();
    #1 clr = 1'b0;
    #2;
    pushExp("rst_mem_req", 0);  popCheck(memReq);
    pushExp("rst_mem_busy", 0); popCheck(memBusy);
    pushExp("rst_mem_err", 0);  popCheck(memErr);
    pushExp("rst_out_port", 0); popCheck(outPort);
    pushExp("rst_con_out", 0);  popCheck(conOut);
    clr = 1'b1;
    tick();

    // EXT -> R3 -> out_port; R0 visible normally, zero under ba_mode
    regIn = 16'h0008; applyStimulus(S_EXT, 32'h0000_00A5);
    outIn = 1; pushExp("out_from_r3", 32'hA5); applyStimulus(5'd3, 0);
    popCheck(outPort);
    regIn = 16'h0001; applyStimulus(S_EXT, 32'h77);
    pushExp("r0_plain", 32'h77); readBus(5'd0, v); popCheck(v);
    baMode = 1; outIn = 1; pushExp("out_from_r0_ba", 0); applyStimulus(5'd0, 0);
    popCheck(outPort); baMode = 0;
    pushExp("bus_out_of_range", 0); readBus(5'd25, v); popCheck(v);

    // Several destinations from one bus value
    regIn = 16'h0030; pcIn = 1; applyStimulus(S_EXT, 32'h1234_5678);
    pushExp("multi_r4", 32'h1234_5678); readBus(5'd4, v); popCheck(v);
    pushExp("multi_r5", 32'h1234_5678); readBus(5'd5, v); popCheck(v);
    pushExp("multi_pc", 32'h1234_5678); readBus(S_PC, v); popCheck(v);

    // Input port capture
    inData = 32'hCAFE_0001; inStrobe = 1; tick(); inStrobe = 0; inData = 32'h0;
    pushExp("inport", 32'hCAFE_0001); readBus(S_INPORT, v); popCheck(v);

    // CSEXT sign extension, both signs
    irIn = 1; pushExp("ir_out", 32'h0017_FFFF); applyStimulus(S_EXT, 32'h0017_FFFF);
    popCheck(irOut);
    yIn = 1; pushExp("csext_neg", 32'hFFFF_FFFF); applyStimulus(S_CSEXT, 0);
    popCheck(aluA);
    irIn = 1; applyStimulus(S_EXT, 32'h0003_1234);
    yIn = 1; pushExp("csext_pos", 32'h0003_1234); applyStimulus(S_CSEXT, 0);
    popCheck(aluA);

    // CON conditions
    irIn = 1; applyStimulus(S_EXT, 32'h0008_0000);
    conIn = 1; pushExp("con_nez_5", 1); applyStimulus(S_EXT, 32'd5); popCheck(conOut);
    conIn = 1; pushExp("con_nez_0", 0); applyStimulus(S_EXT, 32'd0); popCheck(conOut);
    irIn = 1; applyStimulus(S_EXT, 32'h0018_0000);
    conIn = 1; pushExp("con_neg", 1); applyStimulus(S_EXT, 32'h8000_0000); popCheck(conOut);
    irIn = 1; applyStimulus(S_EXT, 32'h0010_0000);
    conIn = 1; pushExp("con_pos", 0); applyStimulus(S_EXT, 32'h8000_0000); popCheck(conOut);
    irIn = 1; applyStimulus(S_EXT, 32'h0000_0000);
    conIn = 1; pushExp("con_eqz", 1); applyStimulus(S_EXT, 32'd0); popCheck(conOut);

    // Z split into HI/LO
    aluRes = 64'h0000_0001_0000_0002; zIn = 1; applyStimulus(S_EXT, 0);
    aluRes = '0;
    hiIn = 1; applyStimulus(S_ZHI, 0);
    loIn = 1; applyStimulus(S_ZLO, 0);
    pushExp("hi_from_zhi", 32'd1); readBus(S_HI, v); popCheck(v);
    pushExp("lo_from_zlo", 32'd2); readBus(S_LO, v); popCheck(v);

    // Read with three wait states; MAR and MDR loads blocked meanwhile
    marIn = 1; applyStimulus(S_EXT, 32'h0000_010C);
    mdrIn = 1; applyStimulus(S_EXT, 32'h1111_1111);
    doneBase = doneSeen;
    memRd = 1; tick(); memRd = 0;
    pushExp("rd_req", 1); popCheck(memReq);
    pushExp("rd_we", 0);  popCheck(memWe);
    for (int w = 0; w < 3; w++) begin
      pushExp("rd_addr_wait", 32'h10C); popCheck(memAddr);
      if (w == 1) begin
        marIn = 1; applyStimulus(S_EXT, 32'h0000_0055);
      end else if (w == 2) begin
        mdrIn = 1; applyStimulus(S_EXT, 32'h2222_2222);
      end else begin
        tick();
      end
    end
    pushExp("rd_addr_ack", 32'h10C);  popCheck(memAddr);
    pushExp("rd_mdr_held", 32'h1111_1111); popCheck(memWdata);
    memAck = 1; memRdata = 32'hDEAD_BEEF; tick(); memAck = 0; memRdata = '0;
    pushExp("rd_done", 1); popCheck(memDone);
    pushExp("rd_mdr", 32'hDEAD_BEEF); popCheck(memWdata);
    pushExp("rd_req_drop", 0); popCheck(memReq);
    tick();
    pushExp("rd_done_pulses", 1); popCheck(doneSeen - doneBase);
    pushExp("mar_after_rd", 32'h10C); popCheck(memAddr);

    // Minimum-latency write
    mdrIn = 1; applyStimulus(S_EXT, 32'hA0A0_A0A0);
    doneBase = doneSeen;
    memWr = 1; tick(); memWr = 0;
    pushExp("wr_req", 1); popCheck(memReq);
    pushExp("wr_we", 1);  popCheck(memWe);
    pushExp("wr_wdata", 32'hA0A0_A0A0); popCheck(memWdata);
    memAck = 1; tick(); memAck = 0;
    pushExp("wr_done", 1); popCheck(memDone);
    pushExp("wr_req_drop", 0); popCheck(memReq);
    tick();
    pushExp("wr_done_pulses", 1); popCheck(doneSeen - doneBase);
    pushExp("err_clean", 0); popCheck(memErr);

    // Write timeout: no ack ever
    doneBase = doneSeen;
    memWr = 1; tick(); memWr = 0;
    reqCycles = 0;
    for (int g = 0; g < 40 && memReq === 1'b1; g++) begin
      reqCycles++;
      tick();
    end
    pushExp("wr_timeout_cycles", 15); popCheck(reqCycles);
    pushExp("wr_timeout_err", 1); popCheck(memErr);
    pushExp("wr_timeout_busy", 0); popCheck(memBusy);
    tick();
    pushExp("wr_timeout_nodone", 0); popCheck(doneSeen - doneBase);

    // Read timeout leaves MDR alone
    memRdata = 32'hBADB_AD00;
    memRd = 1; tick(); memRd = 0;
    reqCycles = 0;
    for (int g = 0; g < 40 && memReq === 1'b1; g++) begin
      reqCycles++;
      tick();
    end
    memRdata = '0;
    pushExp("rd_timeout_cycles", 15); popCheck(reqCycles);
    pushExp("rd_timeout_mdr", 32'hA0A0_A0A0); popCheck(memWdata);

    // Asynchronous reset in the middle of a read
    memRd = 1; tick(); memRd = 0;
    pushExp("pre_rst_req", 1); popCheck(memReq);
    #2 clr = 1'b0;
    #1;
    pushExp("arst_req", 0);      popCheck(memReq);
    pushExp("arst_busy", 0);     popCheck(memBusy);
    pushExp("arst_err", 0);      popCheck(memErr);
    pushExp("arst_out", 0);      popCheck(outPort);
    pushExp("arst_alu_a", 0);    popCheck(aluA);
    pushExp("arst_ir", 0);       popCheck(irOut);
    pushExp("arst_mdr", 0);      popCheck(memWdata);
    pushExp("arst_mar", 0);      popCheck(memAddr);
    pushExp("arst_r3", 0);       readBus(5'd3, v); popCheck(v);
    pushExp("arst_hi", 0);       readBus(S_HI, v); popCheck(v);
    #1 clr = 1'b1;
    tick();

    // Conflicting start: error, no request
    memRd = 1; memWr = 1; tick(); memRd = 0; memWr = 0;
    pushExp("conflict_err", 1); popCheck(memErr);
    pushExp("conflict_req", 0); popCheck(memReq);
    tick();
    pushExp("conflict_busy", 0); popCheck(memBusy);
    pushExp("err_sticky", 1); popCheck(memErr);

    checkOutput("sb_leftover", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/param_bus_datapath.md
Name: param_bus_datapath

Overview:
- Parametrised single-bus datapath: NREG general registers, HI/LO, PC, IR, Y, 64-bit-style Z (2×DATA_W), MAR/MDR, CON flip-flop, in/out ports.
- Memory moves through a req/ack handshake FSM with wait states and timeout, replacing a combinational RAM hookup.
- The ALU is external: this block drives its operands and latches its result into Z.
- Sits between the control unit (which drives micro-signals) and the memory/IO subsystem.

Parameters:
DATA_W, 32, datapath width; must be ≥32 because IR fields are fixed at bits 31:0.
NREG, 16, number of general registers; 2..32.
ADDR_W, 9, memory address width taken from MAR[ADDR_W-1:0].
MAX_WAIT, 15, maximum cycles to wait for mem_ack before aborting.

Ports:
clk  in  1  rising-edge clock
clr  in  1  asynchronous active-low reset
bus_src  in  SRC_W=clog2(NREG+9)  encoded bus source: 0..NREG-1 = Rn; then NREG+0 HI, +1 LO, +2 ZHI, +3 ZLO, +4 PC, +5 MDR, +6 INPORT, +7 CSEXT, +8 EXT
reg_in  in  NREG  per-register load enables
hi_in, lo_in, pc_in, ir_in, y_in, z_in, mar_in, mdr_in, con_in, out_in  in  1 each  load enables
ba_mode  in  1  base-address mode: R0 reads as zero
ext_bus  in  DATA_W  external/debug bus value
alu_a  out  DATA_W  Y register contents
alu_b  out  DATA_W  current bus value
alu_res  in  2*DATA_W  ALU result
mem_rd, mem_wr  in  1  start a memory read or write (one-cycle pulse)
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data
mem_ack  in  1  memory acknowledge
mem_busy  out  1  FSM not IDLE
mem_done  out  1  one-cycle pulse on completion
mem_err  out  1  sticky error flag
in_data  in  DATA_W  input port data
in_strobe  in  1  capture in_data
out_port  out  DATA_W  output port register
ir_out  out  DATA_W  IR contents
con_out  out  1  CON flip-flop

Behaviour:
- Reset (clr=0, asynchronous): all registers, out_port, con_out, mem_err = 0; FSM = IDLE; mem_req, mem_we, mem_done, mem_busy = 0.
- Bus: combinational mux selected by bus_src. R0 reads as 0 when ba_mode=1. An out-of-range code reads as 0.
- CSEXT: IR[18:0] sign-extended to DATA_W.
- Register writes: each enabled destination latches the bus at the rising edge. Multiple destinations in one cycle are legal.
- Z: latches alu_res when z_in. ZHI = upper DATA_W bits, ZLO = lower DATA_W bits.
- In port: captures in_data on the cycle in_strobe is high.
- Out port: latches the bus when out_in.
- CON: when con_in, con_out <= condition on the bus, selected by IR[20:19]:
  - 00: bus == 0
  - 01: bus != 0
  - 10: bus[DATA_W-1] == 0
  - 11: bus[DATA_W-1] == 1
- MDR: loads the bus when mdr_in and not in RD. A read completion overrides mdr_in in the same cycle.
- MAR: loads the bus when mar_in and the FSM is IDLE; it is held while busy.
- Memory FSM, states IDLE, RD, WR:
  - IDLE + mem_rd (alone) -> RD next cycle.
  - IDLE + mem_wr (alone) -> WR next cycle.
  - IDLE + mem_rd & mem_wr together -> stay IDLE, set mem_err.
  - In RD/WR: mem_req=1, mem_addr=MAR[ADDR_W-1:0], mem_we=(WR), mem_wdata=MDR. These are held stable until ack.
  - RD + mem_ack: MDR <= mem_rdata, mem_done pulse, -> IDLE.
  - WR + mem_ack: mem_done pulse, -> IDLE.
  - Wait counter resets on entry and increments each cycle without ack. When the count reaches MAX_WAIT with no ack: -> IDLE, mem_err=1, no mem_done, MDR unchanged.
  - mem_rd/mem_wr while busy are ignored.
  - Minimum latency: request pulse at cycle N, mem_req at N+1, ack at N+1 gives mem_done at N+2 and MDR valid at N+2.
- mem_err: cleared only by reset.
- alu_a = Y; alu_b = bus.

Decomposition:
- Package param_bus_datapath_pkg contains:
  - source-select offset constants (SRC_HI .. SRC_EXT as offsets from NREG);
  - CON condition codes;
  - memory FSM state enum;
  - SRC_W function.
- Sub-module mem_if_fsm: FSM, wait counter, req/ack outputs, mem_done/mem_err.

Test Plan:
- Reset mid-RD (mem_req=1), clr low -> mem_req=0, FSM IDLE, all registers 0 immediately, without waiting for a clock.
- EXT=0x0000_00A5, reg_in[3]=1; then bus_src=R3, out_in=1 -> out_port=0xA5. Repeat with R0, ba_mode=1 -> out_port=0.
- IR=0x0017_FFFF (IR[18]=1), bus_src=CSEXT, y_in -> alu_a=0xFFFF_FFFF. IR[20:19]=01 with bus=5, con_in -> con_out=1; bus=0 -> con_out=0.
- MAR=0x1_0C, mem_rd, ack after 3 wait cycles with rdata=0xDEAD_BEEF:
  - mem_addr=0x10C throughout;
  - MDR=0xDEADBEEF;
  - mem_done pulses once;
  - mar_in during the wait does not change mem_addr.
- mem_wr with ack never asserted, MAX_WAIT=15 -> mem_req drops after 15 cycles, mem_err=1, no mem_done. mem_rd & mem_wr in the same cycle -> mem_err=1, no request.
- alu_res=0x1_0000_0002, z_in; then bus_src=ZHI, hi_in and bus_src=ZLO, lo_in -> HI=1, LO=2.
